// File: rtl/hazard_stall_unit.sv
// ID-stage hazard unit: load-use stalls, data-memory miss freeze and branch flush.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_stall_unit #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_IFID,
  input  logic [4:0]  rt_IFID,
  input  logic        usesRt_IFID,
  input  logic [4:0]  rt_IDEX,
  input  logic        memRead_IDEX,
  input  logic        dmemReq_EXMEM,
  input  logic        dmemReady,
  input  logic        branchTaken_EX,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        ifidFlush,
  output logic        idexWrite,
  output logic        idexBubble,
  output logic        exmemWrite,
  output logic        memwbBubble,
  output logic        memTimeout,
  output logic [15:0] luStallCycles,
  output logic [15:0] memStallCycles
);

  // state    | meaning
  // ST_RUN   | normal flow, hazards detected combinationally
  // ST_LU    | remaining load-use bubbles being inserted
  // ST_MEM   | pipeline frozen on a data-memory miss
  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_LU  = 2'd1;
  localparam logic [1:0] ST_MEM = 2'd2;

  localparam logic [2:0]  LU_INIT  = 3'(LOAD_USE_BUBBLES - 1);
  localparam logic [15:0] TO_LIMIT = 16'(MEM_TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [2:0]  bub_cnt_q, bub_cnt_d;
  logic [2:0]  saved_bub_q, saved_bub_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        timeout_q;

  logic haz_lu, miss_now, timeout_hit;
  logic freeze, flush, lu_stall;
  logic freeze_a, flush_a, lu_a;

  assign haz_lu = memRead_IDEX && (rt_IDEX != 5'd0) &&
                  ((rt_IDEX == rs_IFID) || (usesRt_IFID && (rt_IDEX == rt_IFID)));
  assign miss_now    = dmemReq_EXMEM && !dmemReady;
  assign timeout_hit = (state_q == ST_MEM) && (to_cnt_q == TO_LIMIT);

  always_comb begin
    state_d     = state_q;
    bub_cnt_d   = bub_cnt_q;
    saved_bub_d = saved_bub_q;
    to_cnt_d    = to_cnt_q;
    freeze      = 1'b0;
    flush       = 1'b0;
    lu_stall    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (miss_now) begin
          freeze      = 1'b1;
          saved_bub_d = 3'd0;
          to_cnt_d    = 16'd0;
          state_d     = ST_MEM;
        end else if (branchTaken_EX) begin
          flush = 1'b1;
        end else if (haz_lu) begin
          lu_stall  = 1'b1;
          bub_cnt_d = LU_INIT;
          if (LU_INIT != 3'd0) state_d = ST_LU;
        end
      end
      ST_LU: begin
        if (miss_now) begin
          // the bubble slot of the frozen cycle counts as spent
          freeze      = 1'b1;
          saved_bub_d = bub_cnt_q - 3'd1;
          to_cnt_d    = 16'd0;
          state_d     = ST_MEM;
        end else if (branchTaken_EX) begin
          flush     = 1'b1;
          bub_cnt_d = 3'd0;
          state_d   = ST_RUN;
        end else begin
          lu_stall  = 1'b1;
          bub_cnt_d = bub_cnt_q - 3'd1;
          if (bub_cnt_q == 3'd1) state_d = ST_RUN;
        end
      end
      ST_MEM: begin
        if (!dmemReady) begin
          freeze = 1'b1;
          if (to_cnt_q != 16'hFFFF) to_cnt_d = to_cnt_q + 16'd1;
        end else begin
          saved_bub_d = 3'd0;
          if (saved_bub_q != 3'd0) begin
            bub_cnt_d = saved_bub_q;
            state_d   = ST_LU;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // reset cycle drives default controls regardless of inputs
  assign freeze_a = freeze && reset;
  assign flush_a  = flush && reset;
  assign lu_a     = lu_stall && reset;

  assign pcWrite     = !(freeze_a || lu_a);
  assign ifidWrite   = !(freeze_a || lu_a);
  assign ifidFlush   = flush_a;
  assign idexWrite   = !freeze_a;
  assign idexBubble  = flush_a || lu_a;
  assign exmemWrite  = !freeze_a;
  assign memwbBubble = freeze_a;
  assign memTimeout  = reset && (timeout_q || timeout_hit);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      bub_cnt_q   <= 3'd0;
      saved_bub_q <= 3'd0;
      to_cnt_q    <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bub_cnt_q   <= bub_cnt_d;
      saved_bub_q <= saved_bub_d;
      to_cnt_q    <= to_cnt_d;
      timeout_q   <= timeout_q || timeout_hit;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] lu_cyc_q, mem_cyc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      lu_cyc_q  <= 16'd0;
      mem_cyc_q <= 16'd0;
    end else begin
      if (lu_a && (lu_cyc_q != 16'hFFFF))      lu_cyc_q  <= lu_cyc_q + 16'd1;
      if (freeze_a && (mem_cyc_q != 16'hFFFF)) mem_cyc_q <= mem_cyc_q + 16'd1;
    end
  end

  assign luStallCycles  = lu_cyc_q;
  assign memStallCycles = mem_cyc_q;
`else
  assign luStallCycles  = 16'h0000;
  assign memStallCycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: one instance with 1 bubble / long timeout,
// one with 3 bubbles / timeout 3, sharing the same stimulus.
module tb_hazard_stall_unit;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble, exmemWrite, memwbBubble, memTimeout}
  localparam logic [7:0] DEF   = 8'hD4;
  localparam logic [7:0] DEFTO = 8'hD5;
  localparam logic [7:0] LU    = 8'h1C;
  localparam logic [7:0] FRZ   = 8'h02;
  localparam logic [7:0] FRZTO = 8'h03;
  localparam logic [7:0] FLSH  = 8'hFC;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_IFID, rt_IFID, rt_IDEX;
  logic       usesRt_IFID, memRead_IDEX, dmemReq_EXMEM, dmemReady, branchTaken_EX;

  logic [7:0]  o1, o3;
  logic [15:0] lu1, mem1, lu3, mem3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.LOAD_USE_BUBBLES(1), .MEM_TIMEOUT(255)) u1 (
    .clk(clk), .reset(reset), .rs_IFID(rs_IFID), .rt_IFID(rt_IFID),
    .usesRt_IFID(usesRt_IFID), .rt_IDEX(rt_IDEX), .memRead_IDEX(memRead_IDEX),
    .dmemReq_EXMEM(dmemReq_EXMEM), .dmemReady(dmemReady), .branchTaken_EX(branchTaken_EX),
    .pcWrite(o1[7]), .ifidWrite(o1[6]), .ifidFlush(o1[5]), .idexWrite(o1[4]),
    .idexBubble(o1[3]), .exmemWrite(o1[2]), .memwbBubble(o1[1]), .memTimeout(o1[0]),
    .luStallCycles(lu1), .memStallCycles(mem1)
  );

  hazard_stall_unit #(.LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(3)) u3 (
    .clk(clk), .reset(reset), .rs_IFID(rs_IFID), .rt_IFID(rt_IFID),
    .usesRt_IFID(usesRt_IFID), .rt_IDEX(rt_IDEX), .memRead_IDEX(memRead_IDEX),
    .dmemReq_EXMEM(dmemReq_EXMEM), .dmemReady(dmemReady), .branchTaken_EX(branchTaken_EX),
    .pcWrite(o3[7]), .ifidWrite(o3[6]), .ifidFlush(o3[5]), .idexWrite(o3[4]),
    .idexBubble(o3[3]), .exmemWrite(o3[2]), .memwbBubble(o3[1]), .memTimeout(o3[0]),
    .luStallCycles(lu3), .memStallCycles(mem3)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                     input logic [4:0] rt_ex, input logic mrd, input logic req,
                     input logic rdy, input logic br);
    rs_IFID = rs; rt_IFID = rt; usesRt_IFID = use_rt; rt_IDEX = rt_ex;
    memRead_IDEX = mrd; dmemReq_EXMEM = req; dmemReady = rdy; branchTaken_EX = br;
  endtask

  task automatic idle;
    drv(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [7:0] e1, input logic [7:0] e3);
    #2;
    check({tag, "/u1"}, {8'h00, o1}, {8'h00, e1});
    check({tag, "/u3"}, {8'h00, o3}, {8'h00, e3});
    tick();
  endtask

  initial begin
    // reset cycle with a live hazard still yields defaults
    reset = 1'b0;
    drv(5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    step("rst_haz", DEF, DEF);
    reset = 1'b1;

    // load-use on rs: 1 bubble vs 3 bubbles
    drv(5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    step("lu_a", LU, LU);
    idle();
    step("lu_b", DEF, LU);
    step("lu_c", DEF, LU);
    step("lu_d", DEF, DEF);

    // no hazard: $0, no load, rt not used
    drv(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    step("r0", DEF, DEF);
    drv(5'd2, 5'd0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    step("nold", DEF, DEF);
    drv(5'd5, 5'd2, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    step("nort", DEF, DEF);

    // rt hazard, miss on the second bubble, one bubble left after ready
    drv(5'd5, 5'd2, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    step("mlu_a", LU, LU);
    drv(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("mlu_b", FRZ, FRZ);
    step("mlu_c", FRZ, FRZ);
    drv(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("mlu_rdy", DEF, DEF);
    idle();
    step("mlu_e", DEF, LU);
    step("mlu_f", DEF, DEF);
    #2;
    check("lu_cnt1", lu1, PERF ? 16'd2 : 16'd0);
    check("lu_cnt3", lu3, PERF ? 16'd5 : 16'd0);
    check("mem_cnt3", mem3, PERF ? 16'd2 : 16'd0);
    tick();

    reset = 1'b0;
    step("rst1", DEF, DEF);
    reset = 1'b1;
    #2;
    check("rst_lu1", lu1, 16'd0);
    check("rst_mem1", mem1, 16'd0);
    check("rst_lu3", lu3, 16'd0);
    tick();

    // 4 cycles of not-ready: 4 freeze cycles, release on ready
    drv(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #2;
      check($sformatf("frz4_%0d", i), {8'h00, o1}, {8'h00, FRZ});
      tick();
    end
    drv(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    check("frz4_rdy", {8'h00, o1}, {8'h00, DEF});
    tick();
    idle();
    #2;
    check("frz4_cnt", mem1, PERF ? 16'd4 : 16'd0);
    tick();
    reset = 1'b0;
    step("rst2", DEF, DEF);
    reset = 1'b1;
    step("post_rst2", DEF, DEF);

    // timeout after 3 wait cycles on u3, sticky until reset
    drv(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      step($sformatf("to_%0d", i), FRZ, (i >= 4) ? FRZTO : FRZ);
    drv(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("to_rdy", DEF, DEFTO);
    idle();
    step("to_stk", DEF, DEFTO);
    reset = 1'b0;
    step("rst3", DEF, DEF);
    reset = 1'b1;

    // branch beats load-use; reset during LU_STALL; branch during LU_STALL
    drv(5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    step("br_lu", FLSH, FLSH);
    idle();
    step("br_after", DEF, DEF);
    drv(5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    step("lu_pre_rst", LU, LU);
    reset = 1'b0;
    idle();
    step("rst_mid", DEF, DEF);
    reset = 1'b1;
    step("rst_mid_run", DEF, DEF);
    #2;
    check("rst_mid_lu3", lu3, 16'd0);
    tick();
    drv(5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    step("lu_pre_br", LU, LU);
    drv(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("br_in_lu", FLSH, FLSH);
    idle();
    step("br_discard", DEF, DEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
